// File: rtl/super_shift_register.sv
// Multi-mode shift register with single-step and counted burst operation.
// A burst latches its mode and count, then steps on each enabled edge until the count expires.
module super_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [2:0]       op_mode;
  logic             op_en;
  logic             burstable;
  logic [WIDTH-1:0] op_q;
  logic             op_carry;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    op_mode = mode;
    op_en   = 1'b0;

    burstable = (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
                (mode == MODE_ROL) || (mode == MODE_INC);

    if (state_q == IDLE) begin
      if (start) begin
        // A zero count is a pure no-op; non-repeatable modes execute once immediately.
        if (amt == '0) begin
          done_d = 1'b1;
        end else if (burstable) begin
          mode_d  = mode;
          cnt_d   = amt;
          state_d = RUN;
        end else begin
          op_en  = 1'b1;
          done_d = 1'b1;
        end
      end else begin
        op_en = en;
      end
    end else begin
      op_mode = mode_q;
      if (en) begin
        op_en = 1'b1;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end

    op_q     = q_q;
    op_carry = carry_q;
    case (op_mode)
      MODE_HOLD: op_q = q_q;
      MODE_SHR:  op_q = {sin_r, q_q[WIDTH-1:1]};
      MODE_SHL:  op_q = {q_q[WIDTH-2:0], sin_l};
      MODE_ROR:  op_q = {q_q[0], q_q[WIDTH-1:1]};
      MODE_ROL:  op_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_LOAD: op_q = d;
      MODE_INC: begin
        op_q     = q_q + WIDTH'(1);
        op_carry = &q_q;
      end
      MODE_CLR: begin
        op_q     = '0;
        op_carry = 1'b0;
      end
      default:   op_q = q_q;
    endcase

    q_d     = op_en ? op_q : q_q;
    carry_d = op_en ? op_carry : carry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign zero   = (q_q == '0);
  assign carry  = carry_q;

endmodule

// File: doc/super_shift_register.md
SUPER_SHIFT_REGISTER -- requirements
Module: super_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the register width in bits (minimum 2).
REQ-002 SHALL have parameter AMT_W, default 4, meaning the width of the burst repeat count.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit, meaning the step enable for single operations and the pause control during a burst.
REQ-006 SHALL have port mode, input, 3 bits, meaning the operation select.
REQ-007 SHALL have port d, input, WIDTH bits, meaning the parallel load data.
REQ-008 SHALL have port sin_r, input, 1 bit, meaning the serial input entering the MSB on a right shift.
REQ-009 SHALL have port sin_l, input, 1 bit, meaning the serial input entering the LSB on a left shift.
REQ-010 SHALL have port start, input, 1 bit, meaning the burst request.
REQ-011 SHALL have port amt, input, AMT_W bits, meaning the burst operation count.
REQ-012 SHALL have port q, output, WIDTH bits, meaning the register contents.
REQ-013 SHALL have port sout_r, output, 1 bit, equal to q[0].
REQ-014 SHALL have port sout_l, output, 1 bit, equal to q[WIDTH-1].
REQ-015 SHALL have ports busy, done, zero and carry, each output, 1 bit, meaning burst in progress, one-cycle burst completion pulse, q==0, and increment wrap flag respectively.

Function
REQ-016 SHALL decode mode as follows:
- 000: hold.
- 001: SHR, q<={sin_r,q[W-1:1]}.
- 010: SHL, q<={q[W-2:0],sin_l}.
- 011: ROR.
- 100: ROL.
- 101: load d.
- 110: increment modulo 2^WIDTH.
- 111: clear to 0.
REQ-017 SHALL use a two-state FSM, IDLE and RUN, with a down-counter of AMT_W bits.
REQ-018 SHALL, in IDLE with start=0 and en=1, apply mode exactly once at the clock edge; with en=0 q SHALL hold.
REQ-019 SHALL, in IDLE with start=1 (en ignored), mode in {001,010,011,100,110} and amt>0, latch mode and amt without changing q, then enter RUN.
REQ-020 SHALL, in RUN, apply the latched mode on each edge with en=1 and decrement the counter; an edge with en=0 SHALL hold q and the counter (pause).
REQ-021 SHALL sample sin_r and sin_l live on each RUN operation edge; mode, d, amt and start SHALL be ignored while in RUN.
REQ-022 SHALL return to IDLE on the edge performing the final operation, and SHALL pulse done high for exactly the following cycle.
REQ-023 SHALL hold busy high in every cycle in which the state is RUN; busy and done SHALL never be high in the same cycle.
REQ-024 SHALL treat start with amt=0 as a no-op: q unchanged, busy stays low, and done pulses in the next cycle.
REQ-025 SHALL treat start with mode in {000,101,111} as a single immediate operation: busy stays low, and done pulses in the next cycle.
REQ-026 SHALL, on an increment, set carry to 1 if q was all-ones before the increment and to 0 otherwise.
REQ-027 SHALL clear carry on a clear operation, and SHALL leave carry unchanged on all other modes.
REQ-028 SHALL drive zero, sout_r and sout_l combinationally from q.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set q=0, carry=0, busy=0, done=0, the counter to 0 and the state to IDLE.
REQ-030 SHALL give rst priority over all other inputs; rst during RUN SHALL abort the burst with no done pulse.

Verification (WIDTH=8, AMT_W=4)
REQ-031 SHALL pass: load 0xA5, then single SHR with sin_r=1 -> q=0xD2, sout_r=0, sout_l=1.
REQ-032 SHALL pass: q=0x81, start ROL amt=3 -> q=0x03,0x06,0x0C on successive edges; busy high 3 cycles; done high 1 cycle after the last operation.
REQ-033 SHALL pass: q=0xFE, start increment amt=2 -> q=0xFF then 0x00; carry=1, zero=1, done pulses once.
REQ-034 SHALL pass: q=0x01, start SHL amt=4 with sin_l=0 and en=0 for 2 cycles mid-burst -> final q=0x10; busy high 6 cycles.
REQ-035 SHALL pass: rst=1 after 2 operations of a ROR amt=5 burst -> q=0x00, busy=0, no done pulse.
REQ-036 SHALL pass: start with amt=0 and mode=001 -> q unchanged, busy never high, done high for 1 cycle.
